// File: rtl/clk_div_checker.sv
// Receive-side monitor for a /DIV divided clock in the same clock domain.
// Measures high/low phase lengths, flags bad phases and timeouts, and reports lock.
module clk_div_checker #(
  parameter int DIV      = 10,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_divIn,
  output logic             o_risePulse,
  output logic             o_fallPulse,
  output logic [CNT_W-1:0] o_highLen,
  output logic [CNT_W-1:0] o_lowLen,
  output logic             o_periodValid,
  output logic             o_locked,
  output logic             o_err,
  output logic [7:0]       o_errCnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MEAS   = 2'd1,
    LOCKED = 2'd2
  } stateT;

  localparam int HALF  = DIV / 2;
  localparam int MIN_I = (HALF > TOL) ? (HALF - TOL) : 0;
  localparam int MAX_I = HALF + TOL;
  localparam int GC_W  = $clog2(LOCK_CNT + 1);

  localparam logic [CNT_W-1:0] GOOD_MIN = CNT_W'(MIN_I);
  localparam logic [CNT_W-1:0] GOOD_MAX = CNT_W'(MAX_I);
  localparam logic [CNT_W-1:0] DIV_LEN  = CNT_W'(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GC_W-1:0]  LOCK_VAL = GC_W'(LOCK_CNT);

  stateT            r_state;
  stateT            w_stateNext;

  logic             r_s1;
  logic             r_s2;
  logic             r_s3;
  logic [CNT_W-1:0] r_cnt;
  logic [GC_W-1:0]  r_goodCnt;
  logic             r_highOk;
  logic             r_risePulse;
  logic             r_fallPulse;
  logic [CNT_W-1:0] r_highLen;
  logic [CNT_W-1:0] r_lowLen;
  logic             r_periodValid;
  logic             r_locked;
  logic             r_err;
  logic [7:0]       r_errCnt;

  logic             w_rise;
  logic             w_fall;
  logic             w_edge;
  logic             w_good;
  logic [CNT_W-1:0] w_cntNext;
  logic [GC_W-1:0]  w_goodCntInc;
  logic [GC_W-1:0]  w_goodCntNext;
  logic             w_highOkNext;
  logic [CNT_W-1:0] w_highLenNext;
  logic [CNT_W-1:0] w_lowLenNext;
  logic             w_periodValidNext;
  logic             w_errNext;
  logic [7:0]       w_errCntNext;

  // Edge detection, phase-length judgement and the free-running length counter.
  always_comb begin
    w_rise       = r_s2 & ~r_s3;
    w_fall       = ~r_s2 & r_s3;
    w_edge       = w_rise | w_fall;
    w_good       = (r_cnt >= GOOD_MIN) && (r_cnt <= GOOD_MAX);
    w_goodCntInc = (r_goodCnt == LOCK_VAL) ? r_goodCnt : r_goodCnt + 1'b1;
    if (w_edge) begin
      w_cntNext = CNT_ONE;
    end else if (r_cnt == CNT_MAX) begin
      w_cntNext = r_cnt;
    end else begin
      w_cntNext = r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_stateNext       = r_state;
    w_goodCntNext     = r_goodCnt;
    w_highOkNext      = r_highOk;
    w_highLenNext     = r_highLen;
    w_lowLenNext      = r_lowLen;
    w_periodValidNext = 1'b0;
    w_errNext         = 1'b0;

    case (r_state)
      IDLE: begin
        // The first edge only synchronises; its length is meaningless.
        if (w_edge) begin
          w_stateNext  = MEAS;
          w_highOkNext = 1'b0;
        end
      end

      MEAS, LOCKED: begin
        if (w_edge) begin
          if (w_fall) begin
            w_highLenNext = r_cnt;
            w_highOkNext  = w_good;
          end else begin
            w_lowLenNext = r_cnt;
            w_highOkNext = 1'b0;
            if (w_good && r_highOk) begin
              w_periodValidNext = 1'b1;
              w_goodCntNext     = w_goodCntInc;
              if (w_goodCntInc == LOCK_VAL) begin
                w_stateNext = LOCKED;
              end
            end
          end
          if (!w_good) begin
            w_errNext     = 1'b1;
            w_goodCntNext = '0;
            w_stateNext   = MEAS;
          end
        end else if (r_cnt == DIV_LEN) begin
          // Input stopped toggling: drop back and resynchronise on the next edge.
          w_errNext     = 1'b1;
          w_goodCntNext = '0;
          w_stateNext   = IDLE;
        end
      end

      default: begin
        w_stateNext   = IDLE;
        w_goodCntNext = '0;
      end
    endcase

    if (w_errNext && (r_errCnt != 8'hFF)) begin
      w_errCntNext = r_errCnt + 8'd1;
    end else begin
      w_errCntNext = r_errCnt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1          <= 1'b0;
      r_s2          <= 1'b0;
      r_s3          <= 1'b0;
      r_cnt         <= '0;
      r_goodCnt     <= '0;
      r_highOk      <= 1'b0;
      r_risePulse   <= 1'b0;
      r_fallPulse   <= 1'b0;
      r_highLen     <= '0;
      r_lowLen      <= '0;
      r_periodValid <= 1'b0;
      r_locked      <= 1'b0;
      r_err         <= 1'b0;
      r_errCnt      <= '0;
    end else begin
      r_s1          <= i_divIn;
      r_s2          <= r_s1;
      r_s3          <= r_s2;
      r_cnt         <= w_cntNext;
      r_goodCnt     <= w_goodCntNext;
      r_highOk      <= w_highOkNext;
      r_risePulse   <= w_rise;
      r_fallPulse   <= w_fall;
      r_highLen     <= w_highLenNext;
      r_lowLen      <= w_lowLenNext;
      r_periodValid <= w_periodValidNext;
      r_locked      <= (w_stateNext == LOCKED);
      r_err         <= w_errNext;
      r_errCnt      <= w_errCntNext;
    end
  end

  assign o_risePulse   = r_risePulse;
  assign o_fallPulse   = r_fallPulse;
  assign o_highLen     = r_highLen;
  assign o_lowLen      = r_lowLen;
  assign o_periodValid = r_periodValid;
  assign o_locked      = r_locked;
  assign o_err         = r_err;
  assign o_errCnt      = r_errCnt;

endmodule
